// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and helpers
// for the data-cache to memory bridge.
package dcache_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_WORD_BYTES = DEF_DATA_W / 8;
  localparam int DEF_WORD_OFF   = $clog2(DEF_WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int line_off_bits(
    input int words,
    input int word_bytes
  );
    return $clog2(words) + $clog2(word_bytes);
  endfunction

endpackage

// File: rtl/dcache_mem_bridge_if.sv
// Cache-side line request and memory-side
// word bus seen by the bridge.
interface dcache_mem_bridge_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
);

  logic                         mem_r;
  logic                         mem_w;
  logic [ADDR_W-1:0]            mem_addr;
  logic [LINE_WORDS*DATA_W-1:0] mem_wdata;
  logic [LINE_WORDS*DATA_W-1:0] mem_rdata;
  logic                         mem_ready;
  logic                         bus_req;
  logic                         bus_we;
  logic [ADDR_W-1:0]            bus_addr;
  logic [DATA_W-1:0]            bus_wdata;
  logic                         bus_ack;
  logic [DATA_W-1:0]            bus_rdata;

  modport slave (
    input  mem_r, mem_w, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport master (
    output mem_r, mem_w, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/dcache_line_buf.sv
// One cache line of word registers with
// per-word write enables and a flat output.
module dcache_line_buf #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LINE_WORDS-1:0]        we,
  input  logic [LINE_WORDS*DATA_W-1:0] wdata,
  output logic [LINE_WORDS*DATA_W-1:0] line
);

  logic [LINE_WORDS*DATA_W-1:0] line_q;
  logic [LINE_WORDS*DATA_W-1:0] line_d;

  always_comb begin
    line_d = line_q;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (we[i]) begin
        line_d[i*DATA_W +: DATA_W] =
          wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/dcache_mem_bridge.sv
// Splits line read / write-back requests into
// LINE_WORDS single-word req/ack bus beats.
module dcache_mem_bridge
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input logic                clk,
  input logic                rst,
  dcache_mem_bridge_if.slave io
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int WB_SH  = $clog2(DATA_W / 8);
  localparam int OFF_W  =
    line_off_bits(LINE_WORDS, DATA_W / 8);
  localparam int LINE_W = LINE_WORDS * DATA_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [ADDR_W-1:0]     off_mask;
  logic [ADDR_W-1:0]     aligned;
  logic [LINE_WORDS-1:0] wlat_we;
  logic [LINE_WORDS-1:0] rbuf_we;
  logic [LINE_W-1:0]     wline;
  logic [LINE_W-1:0]     rline;
  logic                  busy;

  assign off_mask = ADDR_W'((1 << OFF_W) - 1);
  assign aligned  = io.mem_addr & ~off_mask;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    wlat_we = '0;
    rbuf_we = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (io.mem_w) begin
          base_d  = aligned;
          beat_d  = '0;
          wlat_we = '1;
          state_d = ST_WRITE;
        end else if (io.mem_r) begin
          base_d  = aligned;
          beat_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_WRITE, ST_READ: begin
        if (io.bus_ack) begin
          if (state_q == ST_READ) begin
            rbuf_we[beat_q] = 1'b1;
          end
          if (beat_q == CNT_W'(LINE_WORDS - 1)) begin
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  dcache_line_buf #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_wlat (
    .clk   (clk),
    .rst   (rst),
    .we    (wlat_we),
    .wdata (io.mem_wdata),
    .line  (wline)
  );

  // every word slot sees the bus word; the
  // beat's enable picks the one that lands
  dcache_line_buf #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_rbuf (
    .clk   (clk),
    .rst   (rst),
    .we    (rbuf_we),
    .wdata ({LINE_WORDS{io.bus_rdata}}),
    .line  (rline)
  );

  assign busy = (state_q == ST_WRITE)
             || (state_q == ST_READ);

  assign io.bus_req   = busy;
  assign io.bus_we    = (state_q == ST_WRITE);
  assign io.bus_addr  = busy
    ? base_q + (ADDR_W'(beat_q) << WB_SH) : '0;
  assign io.bus_wdata = busy
    ? wline[beat_q*DATA_W +: DATA_W] : '0;
  assign io.mem_ready = (state_q == ST_DONE);
  assign io.mem_rdata = rline;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Self-checking bench: transaction-level beat
// and completion model with a memory responder.
module tb_dcache_mem_bridge;

  logic clk;
  logic rst;

  dcache_mem_bridge_if #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)
  ) bif ();

  dcache_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    bit          last;
  } beat_t;

  typedef struct {
    bit           rd;
    logic [127:0] line;
  } cmp_t;

  beat_t bq[$];
  cmp_t  cq[$];
  beat_t b;
  cmp_t  c;

  logic [31:0]  mem [logic [31:0]];
  logic [127:0] last_rd;
  bit           ready_due;
  int           ack_delay;
  int           wcnt;
  bit           force_ack;
  int           errors;
  int           checks;
  int           n;

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(
    input logic [31:0] a
  );
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic push_line(
    input bit           rd,
    input logic [31:0]  addr,
    input logic [127:0] wline
  );
    logic [31:0]  base;
    logic [127:0] line;
    base = addr & 32'hFFFF_FFF0;
    line = wline;
    for (int i = 0; i < 4; i++) begin
      if (rd) line[i*32 +: 32] = memval(base + 4*i);
      bq.push_back('{base + 32'(4*i), !rd,
                     line[i*32 +: 32], i == 3});
    end
    cq.push_back('{rd, line});
  endtask

  task automatic req(
    input bit           w,
    input bit           r,
    input logic [31:0]  addr,
    input logic [127:0] wd,
    input int           dly
  );
    ack_delay     = dly;
    bif.mem_addr  = addr;
    bif.mem_wdata = wd;
    if (w) push_line(1'b0, addr, wd);
    if (r) push_line(1'b1, addr, '0);
    bif.mem_w = w;
    bif.mem_r = r;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #2;
      cyc++;
    end while (!bif.mem_ready && cyc < 60);
    if (!bif.mem_ready)
      chk("ready_timeout", bif.mem_ready, 1);
  endtask

  task automatic next_edge;
    @(posedge clk);
    #2;
  endtask

  // memory side: ack after ack_delay wait cycles
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      bif.bus_ack = 1'b0;
      wcnt = 0;
    end else if (bif.bus_req) begin
      if (wcnt >= ack_delay) begin
        bif.bus_ack = 1'b1;
        wcnt = 0;
      end else begin
        bif.bus_ack = 1'b0;
        wcnt++;
      end
      bif.bus_rdata = memval(bif.bus_addr);
    end else begin
      bif.bus_ack = force_ack;
      wcnt = 0;
      bif.bus_rdata = memval(bif.bus_addr);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("ready_timing", bif.mem_ready, ready_due);
      if (bif.mem_ready) begin
        chk("done_no_req", bif.bus_req, 0);
        chk("ready_expected", cq.size() != 0, 1);
        if (cq.size() != 0) begin
          c = cq.pop_front();
          if (c.rd) begin
            chk("rd_line", bif.mem_rdata, c.line);
            last_rd = c.line;
          end else begin
            chk("wr_keeps_rdata",
                bif.mem_rdata, last_rd);
          end
        end
      end
      ready_due = 1'b0;
      if (bif.bus_req) begin
        chk("req_expected", bq.size() != 0, 1);
        if (bq.size() != 0) begin
          chk("beat_addr", bif.bus_addr, bq[0].addr);
          chk("beat_we", bif.bus_we, bq[0].we);
          if (bq[0].we)
            chk("beat_wdata",
                bif.bus_wdata, bq[0].wdata);
          if (bif.bus_ack) begin
            b = bq.pop_front();
            ready_due = b.last;
          end
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    ready_due = 1'b0;
    last_rd = '0;
    force_ack = 1'b0;
    ack_delay = 0;
    wcnt = 0;
    rst = 1'b0;
    bif.mem_r = 1'b0;
    bif.mem_w = 1'b0;
    bif.mem_addr = '0;
    bif.mem_wdata = '0;
    bif.bus_ack = 1'b0;
    bif.bus_rdata = '0;
    mem[32'h1230] = 32'hA0;
    mem[32'h1234] = 32'hA1;
    mem[32'h1238] = 32'hA2;
    mem[32'h123C] = 32'hA3;

    @(posedge clk);
    #2;
    chk("rst_ready", bif.mem_ready, 0);
    chk("rst_req", bif.bus_req, 0);
    chk("rst_we", bif.bus_we, 0);
    chk("rst_addr", bif.bus_addr, 0);
    chk("rst_wdata", bif.bus_wdata, 0);
    chk("rst_rdata", bif.mem_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    next_edge();

    // plain read, ack every cycle
    req(0, 1, 32'h0000_1234, '0, 0);
    wait_ready(n);
    chk("t1_latency", n, 5);
    chk("t1_rdata", bif.mem_rdata,
        128'h000000A3_000000A2_000000A1_000000A0);
    next_edge();
    bif.mem_r = 1'b0;
    repeat (2) next_edge();

    // write-back, two wait cycles per beat
    req(1, 0, 32'h0000_2004,
        128'h00000044_00000033_00000022_00000011, 2);
    wait_ready(n);
    chk("t2_latency", n, 13);
    chk("t2_rdata_kept", bif.mem_rdata,
        128'h000000A3_000000A2_000000A1_000000A0);
    next_edge();
    bif.mem_w = 1'b0;
    repeat (2) next_edge();

    // both requests: write first, then read
    req(1, 1, 32'h0000_3000,
        128'h13_00000012_00000011_00000010, 0);
    wait_ready(n);
    chk("t3_wr_latency", n, 5);
    next_edge();
    bif.mem_w = 1'b0;
    wait_ready(n);
    chk("t3_rd_latency", n, 5);
    next_edge();
    bif.mem_r = 1'b0;
    repeat (2) next_edge();

    // write-back then fetch on the ready edge
    req(1, 0, 32'h0000_5000,
        128'h55_00000054_00000053_00000052, 0);
    wait_ready(n);
    chk("t4_wr_latency", n, 5);
    next_edge();
    req(0, 1, 32'h0000_6008, '0, 0);
    wait_ready(n);
    chk("t4_rd_latency", n, 5);
    next_edge();
    bif.mem_r = 1'b0;
    next_edge();

    // stray ack while idle
    force_ack = 1'b1;
    repeat (3) next_edge();
    force_ack = 1'b0;
    chk("t5_idle_ack", bif.mem_rdata, last_rd);
    repeat (2) next_edge();

    // inputs change mid-transfer
    req(1, 0, 32'h0000_8000,
        128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, 1);
    repeat (3) @(posedge clk);
    #2;
    bif.mem_addr = 32'h0000_9000;
    bif.mem_wdata = {4{32'hFFFF_FFFF}};
    wait_ready(n);
    chk("t6_latency", n, 6);
    next_edge();
    bif.mem_w = 1'b0;
    repeat (2) next_edge();

    // asynchronous reset during beat 2 of a read
    req(0, 1, 32'h0000_7000, '0, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bif.bus_req &&
                 bif.bus_addr == 32'h7008) && n < 40);
    chk("t7_reached_beat2", bif.bus_addr, 32'h7008);
    #2;
    rst = 1'b0;
    bif.mem_r = 1'b0;
    bif.bus_ack = 1'b0;
    bq.delete();
    cq.delete();
    ready_due = 1'b0;
    last_rd = '0;
    #1;
    chk("t7_req_drop", bif.bus_req, 0);
    chk("t7_ready", bif.mem_ready, 0);
    chk("t7_addr", bif.bus_addr, 0);
    chk("t7_rdata", bif.mem_rdata, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (3) next_edge();
    chk("t7_rdata_post", bif.mem_rdata, 0);
    req(0, 1, 32'h0000_7000, '0, 0);
    wait_ready(n);
    chk("t7_new_latency", n, 5);
    next_edge();
    bif.mem_r = 1'b0;
    repeat (3) next_edge();

    chk("beats_left", bq.size(), 0);
    chk("dones_left", cq.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
